// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, protocol byte values and error codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        LINEACK,
        WAIT_RESP,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_EDGE  = 2'd1;
    localparam logic [1:0] ERR_RESP  = 2'd2;
    localparam logic [1:0] ERR_RETRY = 2'd3;

    // PS/2 frames carry odd parity: data ones plus parity bit is always odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock/data lines and flags device clock falling edges.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_meta_q;
    logic [1:0] data_meta_q;
    logic       clk_prev_q;

    // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
            data_meta_q <= {data_meta_q[0], ps2_data_i};
            clk_prev_q  <= clk_meta_q[1];
        end
    end

    assign data_sync = data_meta_q[1];
    assign clk_fall  = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, RTS, host frame, line-ACK,
// device response with resend handling, optional argument byte.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | lines released, receiver enabled, waiting for a command
// INHIBIT   | clock held low, receiver gated off
// START     | clock and data held low (request-to-send / start bit)
// SEND      | clock released, device clocks data bits, parity and stop
// LINEACK   | waiting for the 11th falling edge with data pulled low by device
// WAIT_RESP | receiver enabled, waiting for 0xFA / 0xFE from the device
// DONE      | one-cycle completion pulse
// ERR       | one-cycle error pulse, err_code latched
module ps2_host_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES    = 5000,
    parameter int unsigned START_HOLD_CYCLES = 50,
    parameter int unsigned EDGE_TIMEOUT      = 1000000,
    parameter int unsigned RESP_TIMEOUT      = 1000000,
    parameter int unsigned MAX_RETRY         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_en,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [31:0] INHIBIT_LOAD = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] HOLD_LOAD    = 32'(START_HOLD_CYCLES - 1);
    localparam logic [31:0] EDGE_LOAD    = 32'(EDGE_TIMEOUT);
    localparam logic [31:0] RESP_LOAD    = 32'(RESP_TIMEOUT);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);

    ps2_state_e  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  arg_q, arg_d;
    logic        has_arg_q, has_arg_d;
    logic        arg_phase_q, arg_phase_d;
    logic        drive_low_q, drive_low_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        data_sync;
    logic        clk_fall;
    logic        timer_zero;
    logic [7:0]  tx_byte;

    ps2_line_sync u_line_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    assign timer_zero = (timer_q == 32'd0);
    assign tx_byte    = arg_phase_q ? arg_q : cmd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= 32'd0;
            edge_cnt_q  <= 4'd0;
            retry_q     <= 8'd0;
            cmd_q       <= 8'd0;
            arg_q       <= 8'd0;
            has_arg_q   <= 1'b0;
            arg_phase_q <= 1'b0;
            drive_low_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            edge_cnt_q  <= edge_cnt_d;
            retry_q     <= retry_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            has_arg_q   <= has_arg_d;
            arg_phase_q <= arg_phase_d;
            drive_low_q <= drive_low_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        edge_cnt_d  = edge_cnt_q;
        retry_d     = retry_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        has_arg_d   = has_arg_q;
        arg_phase_d = arg_phase_q;
        drive_low_d = drive_low_q;
        err_code_d  = err_code_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d       = cmd_byte;
                    arg_d       = cmd_arg;
                    has_arg_d   = cmd_has_arg;
                    arg_phase_d = 1'b0;
                    retry_d     = 8'd0;
                    err_code_d  = ERR_NONE;
                    timer_d     = INHIBIT_LOAD;
                    state_d     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_zero) begin
                    timer_d = HOLD_LOAD;
                    state_d = START;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            START: begin
                if (timer_zero) begin
                    timer_d     = EDGE_LOAD;
                    edge_cnt_d  = 4'd0;
                    drive_low_d = 1'b1;
                    state_d     = SEND;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    timer_d    = EDGE_LOAD;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q < 4'd8) begin
                        drive_low_d = ~tx_byte[edge_cnt_q[2:0]];
                    end else if (edge_cnt_q == 4'd8) begin
                        drive_low_d = ~odd_parity(tx_byte);
                    end else begin
                        drive_low_d = 1'b0;
                        state_d     = LINEACK;
                    end
                end else if (timer_zero) begin
                    err_code_d = ERR_EDGE;
                    state_d    = ERR;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            LINEACK: begin
                if (clk_fall) begin
                    if (!data_sync) begin
                        timer_d = RESP_LOAD;
                        state_d = WAIT_RESP;
                    end else begin
                        err_code_d = ERR_EDGE;
                        state_d    = ERR;
                    end
                end else if (timer_zero) begin
                    err_code_d = ERR_EDGE;
                    state_d    = ERR;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            WAIT_RESP: begin
                // Bytes other than ACK/RESEND are dropped without touching the timer.
                if (rx_valid && (rx_byte == PS2_ACK)) begin
                    if (!arg_phase_q && has_arg_q) begin
                        arg_phase_d = 1'b1;
                        retry_d     = 8'd0;
                        timer_d     = INHIBIT_LOAD;
                        state_d     = INHIBIT;
                    end else begin
                        state_d = DONE;
                    end
                end else if (rx_valid && (rx_byte == PS2_RESEND)) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 8'd1;
                        timer_d = INHIBIT_LOAD;
                        state_d = INHIBIT;
                    end else begin
                        err_code_d = ERR_RETRY;
                        state_d    = ERR;
                    end
                end else if (timer_zero) begin
                    err_code_d = ERR_RESP;
                    state_d    = ERR;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == START);
    assign ps2_data_oe = (state_q == START) || ((state_q == SEND) && drive_low_q);
    assign rx_en       = (state_q == IDLE) || (state_q == WAIT_RESP) ||
                         (state_q == DONE) || (state_q == ERR);
    assign done        = (state_q == DONE);
    assign err         = (state_q == ERR);
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: open-drain PS/2 device model, response injection and outcome model.
module tb_ps2_host_cmd_ctrl;

    localparam int INH     = 20;
    localparam int HOLD    = 6;
    localparam int EDGE_TO = 150;
    localparam int RESP_TO = 250;
    localparam int MAXR    = 3;
    localparam int HALF    = 6;
    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_en, done, err;
    logic [1:0] err_code;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [1:0] last_code = 2'd0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic [9:0] frames_q[$];
    logic [9:0] rbits;
    bit rok;
    int rmode;

    always #5 clk = ~clk;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (HOLD),
        .EDGE_TIMEOUT      (EDGE_TO),
        .RESP_TIMEOUT      (RESP_TO),
        .MAX_RETRY         (MAXR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .cmd_has_arg (cmd_has_arg),
        .cmd_arg     (cmd_arg),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_en       (rx_en),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame as seen by the device: data LSB-first, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] j;
        j = 8'($urandom);
        if (j == B_ACK || j == B_RESEND) j = 8'h55;
        return j;
    endfunction

    // Per-cycle rules on line ownership, receiver gating and pulse shape.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ps2_clk_oe || ps2_data_oe) check("rx_gated", rx_en, 0);
            if (cmd_ready) check("idle_lines", {ps2_clk_oe, ps2_data_oe, rx_en}, 3'b001);
            else if (!err) check("code_clear_busy", err_code, 0);
            check("pulse_excl", done & err, 0);
            if (prev_done) check("done_width", done, 0);
            if (prev_err) check("err_width", err, 0);
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                last_code = err_code;
            end
            prev_done = done;
            prev_err  = err;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    task automatic issue(input logic [7:0] c, input logic ha, input logic [7:0] a);
        int n;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_byte = ~c; cmd_has_arg = ~ha; cmd_arg = ~a;
        check("ready_drop", cmd_ready, 0);
    endtask

    // Device side of one host frame; stop_after>0 stops clocking after that edge.
    task automatic dev_frame(input int stop_after, input bit do_ack,
                             output logic [9:0] bits, output bit ok);
        int n, inh, hold;
        n = 0; inh = 0; hold = 0;
        bits = '0;
        ok = 1'b1;
        while (ps2_clk_i && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_seen", ps2_clk_i, 0);
        if (ps2_clk_i) begin
            ok = 1'b0;
            return;
        end
        check("rx_off_inhibit", rx_en, 0);
        while (!ps2_clk_i && ps2_data_i && inh < 5000) begin
            inh++;
            @(negedge clk);
        end
        while (!ps2_clk_i && !ps2_data_i && hold < 5000) begin
            hold++;
            @(negedge clk);
        end
        check("inhibit_len", inh, INH);
        check("start_hold_len", hold, HOLD);
        check("rts_data_low", ps2_data_i, 0);
        repeat (3) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) bits[e-1] = ps2_data_i;
            repeat (HALF) @(negedge clk);
            if (e == stop_after) return;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic respond(input logic [7:0] b);
        repeat (4) @(negedge clk);
        check("rx_en_resp", rx_en, 1);
        rx_byte = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte = 8'h00;
    endtask

    // mode: 0 normal, 1 device stalls after edge 5, 2 no line-ACK, 3 no response (first frame only).
    task automatic run_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a,
                           input int fe_c, input int fe_a, input int mode, input bit junk);
        int d0, e0, code, n, fe, fm;
        bit fin, ok;
        logic [7:0] b;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt; code = 0; fin = 1'b0;
        frames_q.delete();
        issue(c, ha, a);
        for (int ph = 0; ph < (ha ? 2 : 1) && !fin; ph++) begin
            b  = (ph == 1) ? a : c;
            fe = (ph == 1) ? fe_a : fe_c;
            for (int t = 0; t <= MAXR && !fin; t++) begin
                fm = (ph == 0 && t == 0) ? mode : 0;
                dev_frame((fm == 1) ? 5 : 0, fm != 2, bits, ok);
                if (!ok) begin fin = 1'b1; break; end
                if (fm == 1) begin code = 1; fin = 1'b1; break; end
                frames_q.push_back(bits);
                check("frame_bits", bits, model_frame(b));
                if (fm == 2) begin code = 1; fin = 1'b1; break; end
                if (fm == 3) begin code = 2; fin = 1'b1; break; end
                if (junk) respond(junk_byte());
                if (t < fe) begin
                    respond(B_RESEND);
                    if (t == MAXR) begin code = 3; fin = 1'b1; end
                end else begin
                    respond(B_ACK);
                    break;
                end
            end
        end
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < EDGE_TO + RESP_TO + 200) begin
            @(negedge clk);
            n++;
        end
        check("finish_seen", (done_cnt != d0) || (err_cnt != e0), 1);
        if (mode == 1) check("edge_to_window", (n >= EDGE_TO - 2*HALF - 5) && (n <= EDGE_TO + 5), 1);
        if (mode == 3) check("resp_to_window", (n >= RESP_TO - 2*HALF - 5) && (n <= RESP_TO + 5), 1);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt - d0, (code == 0) ? 1 : 0);
        check("err_count", err_cnt - e0, (code != 0) ? 1 : 0);
        if (code != 0) check("err_code_pulse", last_code, code);
        check("err_code_held", err_code, code);
        check("idle_after", {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_en}, 4'b1001);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_en, done, err, err_code}, 8'b1001_0000);
        rst_n = 1'b1;
        @(negedge clk);

        check("model_f4", model_frame(8'hF4), 10'h2F4);
        check("model_ff", model_frame(8'hFF), 10'h3FF);

        run_cmd(8'hF4, 1'b0, 8'h00, 0, 0, 0, 1'b0);
        check("f4_frames", frames_q.size(), 1);
        if (frames_q.size() >= 1) check("f4_bits", frames_q[0], 10'h2F4);

        run_cmd(8'hED, 1'b1, 8'h07, 0, 0, 0, 1'b0);
        check("led_frames", frames_q.size(), 2);
        if (frames_q.size() >= 2) begin
            check("led_cmd_bits", frames_q[0], 10'h3ED);
            check("led_arg_bits", frames_q[1], 10'h207);
        end

        run_cmd(8'hFF, 1'b0, 8'h00, 2, 0, 0, 1'b0);
        check("resend_frames", frames_q.size(), 3);
        foreach (frames_q[i]) check("resend_bits", frames_q[i], 10'h3FF);

        run_cmd(8'hFF, 1'b0, 8'h00, 4, 0, 0, 1'b0);
        check("exhaust_frames", frames_q.size(), 4);

        run_cmd(8'hED, 1'b1, 8'h02, 0, 4, 0, 1'b0);
        check("arg_exhaust_frames", frames_q.size(), 5);

        run_cmd(8'hF4, 1'b1, 8'h11, 0, 0, 1, 1'b0);
        check("stall_frames", frames_q.size(), 0);

        run_cmd(8'hF2, 1'b1, 8'h11, 0, 0, 2, 1'b0);
        check("noack_frames", frames_q.size(), 1);

        run_cmd(8'hF3, 1'b1, 8'h20, 0, 0, 3, 1'b0);
        run_cmd(8'hED, 1'b1, 8'h05, 1, 1, 0, 1'b1);

        // Reset in the middle of a frame while the host is pulling data low.
        issue(8'hEE, 1'b0, 8'h00);
        dev_frame(5, 1'b1, rbits, rok);
        check("pre_rst_data_oe", ps2_data_oe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_clk_release", ps2_clk_oe, 0);
        check("rst_data_release", ps2_data_oe, 0);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_rx_en", rx_en, 1);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(8'hF4, 1'b0, 8'h00, 0, 0, 0, 1'b0);
        check("post_rst_frames", frames_q.size(), 1);

        for (int i = 0; i < 16; i++) begin
            rmode = $urandom_range(0, 9);
            rmode = (rmode < 7) ? 0 : rmode - 6;
            run_cmd(8'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), rmode, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_cmd_ctrl.md
Name: ps2_host_cmd_ctrl

Overview:
Host-to-device command sequencer for the PS/2 keyboard port. Takes a command byte plus an optional argument byte (e.g. 0xED set-LEDs + mask, 0xFF reset) and drives the open-drain clock/data lines through inhibit, request-to-send, an 11-bit host frame and the device line-ACK. It then waits for the device response byte from the existing ps2 receiver path, retries on 0xFE and reports completion or error. While it owns the line, the receiver is gated off.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before RTS (100 us at 50 MHz)
START_HOLD_CYCLES, 50, cycles data is held low before clk is released
EDGE_TIMEOUT, 1000000, max cycles between device clock falling edges during a frame
RESP_TIMEOUT, 1000000, max cycles from line-ACK to response byte
MAX_RETRY, 3, resends allowed per byte after 0xFE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_byte  in  8  command byte
cmd_has_arg  in  1  send cmd_arg after cmd_byte is ACKed
cmd_arg  in  8  argument byte
ps2_clk_i  in  1  raw PS/2 clock line (asynchronous)
ps2_data_i  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull clock low
ps2_data_oe  out  1  1 = pull data low
rx_valid  in  1  one-cycle strobe: receiver completed a byte
rx_byte  in  8  received byte
rx_en  out  1  receiver enable; 0 while the host drives the line
done  out  1  one-cycle pulse: command (and argument) accepted with 0xFA
err  out  1  one-cycle pulse on failure
err_code  out  2  0 none, 1 edge timeout/no line-ACK, 2 response timeout, 3 retries exhausted

Behaviour:
- Reset values: cmd_ready=1, ps2_clk_oe=0, ps2_data_oe=0, rx_en=1, done=0, err=0, err_code=0. State=IDLE, all counters 0. Asserting rst_n mid-frame releases both lines immediately.
- ps2_clk_i/ps2_data_i pass through 2-flop synchronizers. A falling edge is registered prev=1, cur=0 on the synchronized clock.
- Handshake: accept when cmd_valid && cmd_ready. cmd_byte, cmd_has_arg and cmd_arg are latched. cmd_ready drops the next cycle.
- IDLE -> INHIBIT on accept. ps2_clk_oe=1 and rx_en=0 for INHIBIT_CYCLES.
- INHIBIT -> START: ps2_data_oe=1 (start bit 0) with clk still low, held START_HOLD_CYCLES. Then ps2_clk_oe=0.
- START -> SEND: device-clock falling edges n=1..8 drive data bit n-1, LSB first (ps2_data_oe = ~bit). n=9 drives odd parity (parity = ~^byte). n=10 releases data (stop).
- SEND -> LINEACK: on falling edge 11, sample data. 0 = ACK -> WAIT_RESP with rx_en=1. 1 = err_code 1.
- Any gap of more than EDGE_TIMEOUT cycles between edges in START/SEND/LINEACK -> err_code 1.
- WAIT_RESP on rx_valid:
  - 0xFA: ACK. If this was cmd_byte and the argument is pending -> INHIBIT for the argument; else -> DONE.
  - 0xFE: resend. Retry count < MAX_RETRY -> increment and resend the same byte from INHIBIT; else err_code 3.
  - Any other byte is ignored and does not restart the timer.
- RESP_TIMEOUT expiry in WAIT_RESP -> err_code 2.
- The retry counter clears per byte. The argument byte gets its own MAX_RETRY.
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle, err_code held until the next accept, both lines released, rx_en=1 -> IDLE. No partial argument send after a command error.
- cmd_valid during a busy state is not accepted; the requester holds it.
- Timers are 32-bit and saturate-free; they are reloaded on every state entry and on every edge.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, START, SEND, LINEACK, WAIT_RESP, DONE, ERR); byte constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_CMD_LEDS=8'hED, PS2_CMD_RESET=8'hFF; err_code localparams.
- One natural sub-module: ps2_line_sync (2-flop sync + falling-edge detect), shared later by the ps2 receiver.

Test Plan:
- Cmd 0xF4, no argument; device model clocks 11 edges, ACKs the line, returns 0xFA. Required: sampled host bits 0,0,0,1,0,1,1,1,1 (LSB-first data then parity 0), stop 1; one done pulse; rx_en back to 1.
- Cmd 0xED, argument 0x07; device ACKs both. Required: two frames; second frame data 1,1,1,0,0,0,0,0 with parity 0; done exactly once after the second 0xFA.
- Cmd 0xFF; device answers 0xFE twice, then 0xFA. Required: three identical frames, done=1, err never asserted.
- Device always answers 0xFE with MAX_RETRY=3. Required: 4 frames, then err=1 with err_code=3.
- Device stops clocking after edge 5. Required: err_code=1 after EDGE_TIMEOUT cycles; ps2_clk_oe=0 and ps2_data_oe=0.
- rst_n pulsed low during SEND. Required: lines released immediately; cmd_ready=1 after reset; next command completes normally.
